// File: rtl/rv32_multicycle_core_pkg.sv
// Shared definitions for the multi-cycle RV32I core: opcodes, funct3 codes,
// FSM states, ALU operations and the funct3-to-ALU-op mapping.
package rv32_multicycle_core_pkg;

   localparam logic [6:0] OpcOpImm  = 7'b0010011;
   localparam logic [6:0] OpcOp     = 7'b0110011;
   localparam logic [6:0] OpcLui    = 7'b0110111;
   localparam logic [6:0] OpcAuipc  = 7'b0010111;
   localparam logic [6:0] OpcLoad   = 7'b0000011;
   localparam logic [6:0] OpcStore  = 7'b0100011;
   localparam logic [6:0] OpcBranch = 7'b1100011;
   localparam logic [6:0] OpcJal    = 7'b1101111;
   localparam logic [6:0] OpcJalr   = 7'b1100111;

   // ALU funct3 codes (OP / OP-IMM)
   localparam logic [2:0] F3AddSub = 3'b000;
   localparam logic [2:0] F3Sll    = 3'b001;
   localparam logic [2:0] F3Slt    = 3'b010;
   localparam logic [2:0] F3Sltu   = 3'b011;
   localparam logic [2:0] F3Xor    = 3'b100;
   localparam logic [2:0] F3SrlSra = 3'b101;
   localparam logic [2:0] F3Or     = 3'b110;
   localparam logic [2:0] F3And    = 3'b111;

   // Branch funct3 codes
   localparam logic [2:0] F3Beq  = 3'b000;
   localparam logic [2:0] F3Bne  = 3'b001;
   localparam logic [2:0] F3Blt  = 3'b100;
   localparam logic [2:0] F3Bge  = 3'b101;
   localparam logic [2:0] F3Bltu = 3'b110;
   localparam logic [2:0] F3Bgeu = 3'b111;

   // Memory access size used for instruction fetch
   localparam logic [2:0] F3Word = 3'b010;

   typedef enum logic [2:0] {
      StFetch,
      StDecode,
      StExecute,
      StMemWait,
      StHalt
   } state_t;

   typedef enum logic [3:0] {
      AluAdd,
      AluSub,
      AluSll,
      AluSlt,
      AluSltu,
      AluXor,
      AluSrl,
      AluSra,
      AluOr,
      AluAnd
   } alu_op_t;

   // alt selects SUB for funct3 000 and SRA for funct3 101
   function automatic alu_op_t alu_op_from_f3(input logic [2:0] f3, input logic alt);
      alu_op_t op;
      case (f3)
         F3AddSub: op = alt ? AluSub : AluAdd;
         F3Sll:    op = AluSll;
         F3Slt:    op = AluSlt;
         F3Sltu:   op = AluSltu;
         F3Xor:    op = AluXor;
         F3SrlSra: op = alt ? AluSra : AluSrl;
         F3Or:     op = AluOr;
         F3And:    op = AluAnd;
         default:  op = AluAdd;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/rv32_multicycle_core_alu.sv
// Combinational 32-bit ALU; also serves branch compares (SUB/SLT/SLTU) and
// load/store/JALR address generation (ADD).
module rv32_multicycle_core_alu
   import rv32_multicycle_core_pkg::*;
(
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  alu_op_t     op_i,
   output logic [31:0] result_o
);

   // Operation select
   always_comb begin
      result_o = '0;
      case (op_i)
         AluAdd:  result_o = a_i + b_i;
         AluSub:  result_o = a_i - b_i;
         AluSll:  result_o = a_i << b_i[4:0];
         AluSlt:  result_o = {31'b0, $signed(a_i) < $signed(b_i)};
         AluSltu: result_o = {31'b0, a_i < b_i};
         AluXor:  result_o = a_i ^ b_i;
         AluSrl:  result_o = a_i >> b_i[4:0];
         AluSra:  result_o = 32'($signed(a_i) >>> b_i[4:0]);
         AluOr:   result_o = a_i | b_i;
         AluAnd:  result_o = a_i & b_i;
         default: result_o = '0;
      endcase
   end

endmodule

// File: rtl/rv32_multicycle_core.sv
// Multi-cycle RV32I/RV32E execution controller: FETCH/DECODE/EXECUTE/MEM_WAIT
// FSM over a single shared memory read port, with debug register read-out and
// a retired-instruction counter.
module rv32_multicycle_core
   import rv32_multicycle_core_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0,
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      read_data,
   output logic [31:0]      read_address,
   output logic             write_mem,
   output logic [2:0]       funct3,
   output logic [31:0]      write_address,
   output logic [31:0]      write_data,
   output logic             halted,
   output logic             illegal,
   input  logic [4:0]       dbg_sel,
   output logic [31:0]      dbg_data,
   output logic [CNT_W-1:0] instret
);

   if (NUM_REGS != 32 && NUM_REGS != 16) begin : g_bad_num_regs
      $error("rv32_multicycle_core: NUM_REGS must be 16 or 32");
   end

   localparam int unsigned RegAw = (NUM_REGS == 16) ? 4 : 5;

   state_t            state_q, state_d;
   logic [31:0]       pc_q, pc_d;
   logic [31:0]       ir_q, ir_d;
   logic [31:0]       regs_q [NUM_REGS];
   logic [31:0]       regs_d [NUM_REGS];
   logic [CNT_W-1:0]  instret_q, instret_d;
   logic              halted_q, halted_d;
   logic              illegal_q, illegal_d;
   logic [31:0]       waddr_q, waddr_d;
   logic [31:0]       wdata_q, wdata_d;

   logic [6:0]  opcode;
   logic [2:0]  f3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [31:0] rs1_val, rs2_val;
   logic [31:0] alu_a, alu_b, alu_res;
   alu_op_t     alu_op;
   logic        br_taken;

   function automatic logic reg_ok(input logic [4:0] idx);
      return {27'b0, idx} < NUM_REGS;
   endfunction

   // Only the register fields an encoding actually uses are range-checked
   function automatic logic insn_legal(input logic [31:0] w);
      logic       ok, use_rd, use_rs1, use_rs2;
      logic [2:0] wf3;
      logic [6:0] wf7;
      wf3     = w[14:12];
      wf7     = w[31:25];
      ok      = 1'b1;
      use_rd  = 1'b1;
      use_rs1 = 1'b1;
      use_rs2 = 1'b0;
      case (w[6:0])
         OpcOpImm: begin
            if (wf3 == F3Sll)         ok = (wf7 == 7'b0);
            else if (wf3 == F3SrlSra) ok = (wf7 == 7'b0) || (wf7 == 7'b0100000);
         end
         OpcOp: begin
            use_rs2 = 1'b1;
            ok = (wf7 == 7'b0) ||
                 ((wf7 == 7'b0100000) && (wf3 == F3AddSub || wf3 == F3SrlSra));
         end
         OpcLui, OpcAuipc, OpcJal: use_rs1 = 1'b0;
         OpcJalr: ok = (wf3 == 3'b000);
         OpcLoad: ok = (wf3 != 3'b011) && (wf3 != 3'b110) && (wf3 != 3'b111);
         OpcStore: begin
            use_rd  = 1'b0;
            use_rs2 = 1'b1;
            ok      = (wf3 <= F3Word);
         end
         OpcBranch: begin
            use_rd  = 1'b0;
            use_rs2 = 1'b1;
            ok      = (wf3 != 3'b010) && (wf3 != 3'b011);
         end
         default: ok = 1'b0;
      endcase
      if (use_rd  && !reg_ok(w[11:7]))  ok = 1'b0;
      if (use_rs1 && !reg_ok(w[19:15])) ok = 1'b0;
      if (use_rs2 && !reg_ok(w[24:20])) ok = 1'b0;
      return ok;
   endfunction

   assign opcode = ir_q[6:0];
   assign f3     = ir_q[14:12];
   assign imm_i  = {{20{ir_q[31]}}, ir_q[31:20]};
   assign imm_s  = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
   assign imm_b  = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
   assign imm_u  = {ir_q[31:12], 12'b0};
   assign imm_j  = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

   // Register file reads; x0 and out-of-range indices read as zero
   always_comb begin
      rs1_val  = '0;
      rs2_val  = '0;
      dbg_data = '0;
      if (ir_q[19:15] != 5'd0 && reg_ok(ir_q[19:15])) rs1_val = regs_q[ir_q[15 +: RegAw]];
      if (ir_q[24:20] != 5'd0 && reg_ok(ir_q[24:20])) rs2_val = regs_q[ir_q[20 +: RegAw]];
      if (dbg_sel != 5'd0 && reg_ok(dbg_sel))         dbg_data = regs_q[dbg_sel[RegAw-1:0]];
   end

   // ALU operand and operation selection by opcode
   always_comb begin
      alu_a  = rs1_val;
      alu_b  = imm_i;
      alu_op = AluAdd;
      case (opcode)
         OpcOpImm: alu_op = alu_op_from_f3(f3, (f3 == F3SrlSra) && ir_q[30]);
         OpcOp: begin
            alu_b  = rs2_val;
            alu_op = alu_op_from_f3(f3, ir_q[30]);
         end
         OpcStore: alu_b = imm_s;
         OpcBranch: begin
            alu_b = rs2_val;
            case (f3)
               F3Beq, F3Bne: alu_op = AluSub;
               F3Blt, F3Bge: alu_op = AluSlt;
               default:      alu_op = AluSltu;
            endcase
         end
         default: ;
      endcase
   end

   rv32_multicycle_core_alu u_alu (
      .a_i      (alu_a),
      .b_i      (alu_b),
      .op_i     (alu_op),
      .result_o (alu_res)
   );

   // Branch condition from the ALU compare result
   always_comb begin
      case (f3)
         F3Beq:         br_taken = (alu_res == 32'd0);
         F3Bne:         br_taken = (alu_res != 32'd0);
         F3Blt, F3Bltu: br_taken = alu_res[0];
         F3Bge, F3Bgeu: br_taken = !alu_res[0];
         default:       br_taken = 1'b0;
      endcase
   end

   // FSM next state, architectural updates and retirement
   always_comb begin
      logic        rd_we, retire, ctrl_flow;
      logic [31:0] rd_val, next_pc;
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      regs_d    = regs_q;
      instret_d = instret_q;
      halted_d  = halted_q;
      illegal_d = illegal_q;
      waddr_d   = waddr_q;
      wdata_d   = wdata_q;
      rd_we     = 1'b0;
      rd_val    = '0;
      retire    = 1'b0;
      ctrl_flow = 1'b0;
      next_pc   = pc_q + 32'd4;
      case (state_q)
         StFetch: state_d = StDecode;
         StDecode: begin
            ir_d = read_data;
            if (read_data == 32'd0) begin
               state_d  = StHalt;
               halted_d = 1'b1;
            end else if (!insn_legal(read_data)) begin
               state_d   = StHalt;
               halted_d  = 1'b1;
               illegal_d = 1'b1;
            end else begin
               state_d = StExecute;
            end
         end
         StExecute: begin
            state_d = StFetch;
            retire  = 1'b1;
            case (opcode)
               OpcOpImm, OpcOp: begin
                  rd_we  = 1'b1;
                  rd_val = alu_res;
               end
               OpcLui: begin
                  rd_we  = 1'b1;
                  rd_val = imm_u;
               end
               OpcAuipc: begin
                  rd_we  = 1'b1;
                  rd_val = pc_q + imm_u;
               end
               OpcJal: begin
                  rd_we     = 1'b1;
                  rd_val    = pc_q + 32'd4;
                  ctrl_flow = 1'b1;
                  next_pc   = pc_q + imm_j;
               end
               OpcJalr: begin
                  rd_we     = 1'b1;
                  rd_val    = pc_q + 32'd4;
                  ctrl_flow = 1'b1;
                  next_pc   = alu_res & ~32'd1;
               end
               OpcBranch: begin
                  ctrl_flow = 1'b1;
                  if (br_taken) next_pc = pc_q + imm_b;
               end
               OpcLoad: begin
                  state_d = StMemWait;
                  retire  = 1'b0;
                  next_pc = pc_q;
               end
               OpcStore: begin
                  waddr_d = alu_res;
                  wdata_d = rs2_val;
               end
               default: ;
            endcase
            // A misaligned jump/branch target halts without side effects
            if (ctrl_flow && next_pc[1:0] != 2'b00) begin
               state_d   = StHalt;
               halted_d  = 1'b1;
               illegal_d = 1'b1;
               rd_we     = 1'b0;
               retire    = 1'b0;
            end else begin
               pc_d = next_pc;
            end
         end
         StMemWait: begin
            rd_we   = 1'b1;
            rd_val  = read_data;
            pc_d    = pc_q + 32'd4;
            retire  = 1'b1;
            state_d = StFetch;
         end
         StHalt: ;
         default: state_d = StFetch;
      endcase
      if (retire) instret_d = instret_q + CNT_W'(1);
      if (rd_we && ir_q[11:7] != 5'd0) regs_d[ir_q[7 +: RegAw]] = rd_val;
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StFetch;
         pc_q      <= RESET_PC;
         ir_q      <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
         instret_q <= '0;
         halted_q  <= 1'b0;
         illegal_q <= 1'b0;
         waddr_q   <= '0;
         wdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         regs_q    <= regs_d;
         instret_q <= instret_d;
         halted_q  <= halted_d;
         illegal_q <= illegal_d;
         waddr_q   <= waddr_d;
         wdata_q   <= wdata_d;
      end
   end

   // Memory-side outputs; the store strobe is gated by rst_n so a reset
   // arriving during a store's EXECUTE cycle suppresses the write
   always_comb begin
      read_address  = pc_q;
      funct3        = F3Word;
      write_mem     = 1'b0;
      write_address = waddr_q;
      write_data    = wdata_q;
      case (state_q)
         StExecute: begin
            if (opcode == OpcLoad) begin
               read_address = alu_res;
               funct3       = f3;
            end else if (opcode == OpcStore) begin
               write_mem     = rst_n;
               write_address = alu_res;
               write_data    = rs2_val;
               funct3        = f3;
            end
         end
         StMemWait: begin
            read_address = alu_res;
            funct3       = f3;
         end
         default: ;
      endcase
   end

   assign halted  = halted_q;
   assign illegal = illegal_q;
   assign instret = instret_q;

endmodule

// File: tb/tb_rv32_multicycle_core.sv
// Directed bench for rv32_multicycle_core: small word-addressed memory with a
// one-cycle read latency, a 16-register (RV32E) instance alongside the default.
module tb_rv32_multicycle_core;
   import rv32_multicycle_core_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] d_rdata, d_raddr, d_waddr, d_wdata, d_dbg_data, d_instret;
   logic        d_wmem, d_halted, d_illegal;
   logic [2:0]  d_f3;
   logic [4:0]  d_dbg_sel = 5'd0;

   logic [31:0] e_rdata, e_raddr, e_waddr, e_wdata, e_dbg_data, e_instret;
   logic        e_wmem, e_halted, e_illegal;
   logic [2:0]  e_f3;
   logic [4:0]  e_dbg_sel = 5'd0;

   logic [31:0] prog [256];
   logic [31:0] mem  [256];
   logic        copy_en = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;
   int wm_cnt   = 0;
   int seen08   = 0;
   logic [31:0] wm_addr, wm_data;
   logic [2:0]  wm_f3;

   rv32_multicycle_core dut (
      .clk (clk), .rst_n (rst_n), .read_data (d_rdata), .read_address (d_raddr),
      .write_mem (d_wmem), .funct3 (d_f3), .write_address (d_waddr), .write_data (d_wdata),
      .halted (d_halted), .illegal (d_illegal), .dbg_sel (d_dbg_sel), .dbg_data (d_dbg_data),
      .instret (d_instret)
   );

   rv32_multicycle_core #(.NUM_REGS(16)) dut16 (
      .clk (clk), .rst_n (rst_n), .read_data (e_rdata), .read_address (e_raddr),
      .write_mem (e_wmem), .funct3 (e_f3), .write_address (e_waddr), .write_data (e_wdata),
      .halted (e_halted), .illegal (e_illegal), .dbg_sel (e_dbg_sel), .dbg_data (e_dbg_data),
      .instret (e_instret)
   );

   // Memory: program copy during reset, stores, one-cycle registered reads
   always @(posedge clk) begin
      if (!rst_n && copy_en) mem <= prog;
      else if (d_wmem) mem[d_waddr[9:2]] <= d_wdata;
      d_rdata <= mem[d_raddr[9:2]];
      e_rdata <= prog[e_raddr[9:2]];
   end

   // Store-strobe and fetch-address monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (d_wmem) begin
         wm_cnt  = wm_cnt + 1;
         wm_addr = d_waddr;
         wm_data = d_wdata;
         wm_f3   = d_f3;
      end
      if (rst_n && d_raddr == 32'h8) seen08 = seen08 + 1;
   end

   function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                         input int rd, input int opc);
      return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], opc[6:0]};
   endfunction

   function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1,
                                         input int f3);
      return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1,
                                         input int f3);
      return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] enc_j(input int imm, input int rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_reg(input string tag, input int idx, input logic [31:0] exp);
      d_dbg_sel = idx[4:0];
      #1;
      check(tag, d_dbg_data, exp);
   endtask

   task automatic clear_prog();
      for (int i = 0; i < 256; i++) prog[i] = 32'h0;
   endtask

   task automatic do_reset(input logic copy);
      copy_en = copy;
      rst_n   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n   = 1'b1;
      copy_en = 1'b0;
   endtask

   task automatic run_to_halt(input int budget, output int cycles);
      cycles = 0;
      while (!d_halted && cycles < budget) begin
         @(posedge clk);
         #1;
         cycles++;
      end
   endtask

   initial begin
      int cyc;
      int wm_base, seen_base;

      // 1: reset state, then an all-zero program halts at cycle 2
      clear_prog();
      do_reset(1'b1);
      check("rst_halted", {31'b0, d_halted}, 32'h0);
      check("rst_illegal", {31'b0, d_illegal}, 32'h0);
      check("rst_instret", d_instret, 32'h0);
      check("rst_write_mem", {31'b0, d_wmem}, 32'h0);
      check("rst_funct3", {29'b0, d_f3}, 32'h2);
      check("rst_waddr", d_waddr, 32'h0);
      check("rst_wdata", d_wdata, 32'h0);
      check("rst_pc", d_raddr, 32'h0);
      run_to_halt(20, cyc);
      check("t1_cycles", cyc, 32'd2);
      check("t1_halted", {31'b0, d_halted}, 32'h1);
      check("t1_illegal", {31'b0, d_illegal}, 32'h0);
      check("t1_instret", d_instret, 32'h0);
      check("t1_pc", d_raddr, 32'h0);

      // 2: OP-IMM sign handling
      clear_prog();
      prog[0] = enc_i(-5, 0, 0, 1, OpcOpImm);
      prog[1] = enc_i(0, 1, 2, 2, OpcOpImm);
      prog[2] = enc_i(1, 1, 3, 3, OpcOpImm);
      prog[3] = enc_i(32'h401, 1, 5, 4, OpcOpImm);
      do_reset(1'b1);
      run_to_halt(100, cyc);
      check("t2_cycles", cyc, 32'd14);
      check_reg("t2_x1", 1, 32'hFFFFFFFB);
      check_reg("t2_x2", 2, 32'h1);
      check_reg("t2_x3", 3, 32'h0);
      check_reg("t2_x4", 4, 32'hFFFFFFFD);
      check("t2_instret", d_instret, 32'd4);
      check("t2_illegal", {31'b0, d_illegal}, 32'h0);

      // 3: store then load back
      clear_prog();
      prog[0] = enc_i(32'h100, 0, 0, 1, OpcOpImm);
      prog[1] = enc_s(8, 1, 1, 2);
      prog[2] = enc_i(8, 1, 2, 5, OpcLoad);
      do_reset(1'b1);
      wm_base = wm_cnt;
      run_to_halt(100, cyc);
      check("t3_cycles", cyc, 32'd12);
      check("t3_wm_count", wm_cnt - wm_base, 32'd1);
      check("t3_waddr", wm_addr, 32'h108);
      check("t3_wdata", wm_data, 32'h100);
      check("t3_wf3", {29'b0, wm_f3}, 32'h2);
      check("t3_mem", mem[66], 32'h100);
      check_reg("t3_x5", 5, 32'h100);
      check("t3_instret", d_instret, 32'd3);

      // 4: taken bne skips a word, jal links and jumps
      clear_prog();
      prog[0]  = enc_i(1, 0, 0, 1, OpcOpImm);
      prog[1]  = enc_b(8, 1, 0, 1);
      prog[2]  = enc_i(1, 0, 0, 7, OpcOpImm);
      prog[3]  = enc_j(20, 0);
      prog[8]  = enc_j(12, 1);
      do_reset(1'b1);
      seen_base = seen08;
      run_to_halt(100, cyc);
      check("t4_skip_fetch", seen08 - seen_base, 32'd0);
      check_reg("t4_x7", 7, 32'h0);
      check_reg("t4_x1", 1, 32'h24);
      check("t4_pc", d_raddr, 32'h2C);
      check("t4_instret", d_instret, 32'd4);

      // 5a: unknown opcode
      clear_prog();
      prog[0] = 32'h0000007F;
      do_reset(1'b1);
      run_to_halt(50, cyc);
      check("t5a_halted", {31'b0, d_halted}, 32'h1);
      check("t5a_illegal", {31'b0, d_illegal}, 32'h1);
      check("t5a_instret", d_instret, 32'h0);

      // 5b: slli with nonzero imm[11:5]
      clear_prog();
      prog[0] = enc_i(5, 0, 0, 3, OpcOpImm);
      prog[1] = enc_i(32'h021, 3, 1, 3, OpcOpImm);
      do_reset(1'b1);
      run_to_halt(50, cyc);
      check("t5b_illegal", {31'b0, d_illegal}, 32'h1);
      check_reg("t5b_x3", 3, 32'h5);
      check("t5b_instret", d_instret, 32'd1);

      // 5c: x20 is legal with 32 registers, illegal with 16
      clear_prog();
      prog[0] = enc_i(1, 0, 0, 20, OpcOpImm);
      do_reset(1'b1);
      run_to_halt(50, cyc);
      check_reg("t5c_x20", 20, 32'h1);
      check("t5c_illegal32", {31'b0, d_illegal}, 32'h0);
      check("t5c_halted16", {31'b0, e_halted}, 32'h1);
      check("t5c_illegal16", {31'b0, e_illegal}, 32'h1);
      check("t5c_instret16", e_instret, 32'h0);

      // 5d: misaligned jal target halts without linking
      clear_prog();
      prog[0] = enc_j(6, 1);
      do_reset(1'b1);
      run_to_halt(50, cyc);
      check("t5d_illegal", {31'b0, d_illegal}, 32'h1);
      check_reg("t5d_x1", 1, 32'h0);
      check("t5d_instret", d_instret, 32'h0);
      check("t5d_pc", d_raddr, 32'h0);

      // 6: reset during a store's EXECUTE cycle
      clear_prog();
      prog[0]  = enc_i(32'h40, 0, 0, 1, OpcOpImm);
      prog[1]  = enc_s(0, 1, 1, 2);
      prog[16] = 32'hDEADBEEF;
      do_reset(1'b1);
      repeat (5) @(posedge clk);
      #1;
      check("t6_store_exec", {31'b0, d_wmem}, 32'h1);
      wm_base = wm_cnt;
      rst_n = 1'b0;
      #1;
      check("t6_wm_gated", {31'b0, d_wmem}, 32'h0);
      @(posedge clk);
      #1;
      check("t6_wm_count", wm_cnt - wm_base, 32'd0);
      check("t6_mem", mem[16], 32'hDEADBEEF);
      check_reg("t6_x1", 1, 32'h0);
      check("t6_pc", d_raddr, 32'h0);
      check("t6_waddr", d_waddr, 32'h0);
      check("t6_instret", d_instret, 32'h0);
      rst_n = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
